// File: rtl/hdlc_pkg.sv
// Shared HDLC framing types and constants, used by the transmitter and the planned receiver.
package hdlc_pkg;

    typedef enum logic [2:0] {IDLE, FLAG, DATA, FCS, CLOSE, ABORT} state_t;

    localparam logic [7:0]  HDLC_FLAG = 8'h7E;
    localparam logic [15:0] CRC_POLY  = 16'h8408;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC_GOOD  = 16'hF0B8;
    localparam logic [2:0]  STUFF_RUN = 3'd5;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[0] ^ b;
        return (crc >> 1) ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/hdlc_tx_crc16s.sv
// Serial CRC-16/X.25 (reflected); one bit per en, result visible the cycle after.
// No backpressure: init has priority over en; the receiver checks for CRC_GOOD residual.
module crc16s
    import hdlc_pkg::*;
(
    input  logic        clk,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk) begin
        crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/hdlc_tx.sv
// HDLC/AX.25 serial framer behind a 9-bit FIFO: one registered bit per ce, first flag bit one ce after a word is held.
// Prefetches one word via oe/ov whenever the holding register is free; underrun aborts. HDLC_NRZI_EN selects NRZI line coding.
module hdlc_tx
    import hdlc_pkg::*;
#(
    parameter int unsigned FLAGS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [8:0] pdi,
    input  logic       empty,
    input  logic       ov,
    output logic       oe,
    output logic       sdo,
    output logic       busy,
    output logic       abort
);

    state_t      state_q, state_d;
    logic [8:0]  hold_q, hold_d;
    logic        hvld_q, hvld_d;
    logic        drop_q, drop_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        eof_q, eof_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [3:0]  flagcnt_q, flagcnt_d;
    logic [2:0]  ones_q, ones_d;
    logic        sdo_q, sdo_d;
    logic        abort_q, abort_d;
    logic        tx_bit, stuff, crc_init, crc_en;
    logic [15:0] crc;

    crc16s u_crc (
        .clk    (clk),
        .init   (crc_init),
        .en     (crc_en),
        .bit_in (shreg_q[0]),
        .crc    (crc)
    );

    assign oe    = ~rst & ~hvld_q & ~empty;
    assign sdo   = sdo_q;
    assign abort = abort_q;

    always_comb begin
        stuff  = 1'b0;
        tx_bit = 1'b1;
        busy   = (state_q != IDLE);
        case (state_q)
            FLAG, CLOSE: tx_bit = HDLC_FLAG[bitcnt_q[2:0]];
            DATA: begin
                stuff  = (ones_q == STUFF_RUN);
                tx_bit = stuff ? 1'b0 : shreg_q[0];
            end
            FCS: begin
                stuff  = (ones_q == STUFF_RUN);
                tx_bit = stuff ? 1'b0 : ~crc[bitcnt_q[3:0]];
            end
            default: tx_bit = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        hvld_d    = hvld_q;
        drop_d    = drop_q;
        shreg_d   = shreg_q;
        eof_d     = eof_q;
        bitcnt_d  = bitcnt_q;
        flagcnt_d = flagcnt_q;
        ones_d    = ones_q;
        sdo_d     = sdo_q;
        abort_d   = 1'b0;
        crc_init  = 1'b0;
        crc_en    = 1'b0;

        if (ov) begin
            hold_d = pdi;
            hvld_d = 1'b1;
        end
        // Remainder of an aborted frame is flushed up to and including its eof word.
        if (drop_q && hvld_q) begin
            hvld_d = 1'b0;
            if (hold_q[8]) begin
                drop_d = 1'b0;
            end
        end

        if (ce) begin
`ifdef HDLC_NRZI_EN
            sdo_d = tx_bit ? sdo_q : ~sdo_q;
`else
            sdo_d = tx_bit;
`endif
            if (!stuff && tx_bit && (state_q == DATA || state_q == FCS)) begin
                ones_d = ones_q + 3'd1;
            end else begin
                ones_d = 3'd0;
            end

            case (state_q)
                IDLE: begin
                    if (hvld_q && !drop_q) begin
                        state_d   = FLAG;
                        flagcnt_d = 4'(FLAGS);
                        bitcnt_d  = 5'd0;
                        crc_init  = 1'b1;
                    end
                end
                FLAG: begin
                    bitcnt_d = bitcnt_q + 5'd1;
                    if (bitcnt_q == 5'd7) begin
                        bitcnt_d = 5'd0;
                        if (flagcnt_q == 4'd1) begin
                            state_d = DATA;
                            shreg_d = hold_q[7:0];
                            eof_d   = hold_q[8];
                            hvld_d  = 1'b0;
                        end else begin
                            flagcnt_d = flagcnt_q - 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (!stuff) begin
                        crc_en   = 1'b1;
                        shreg_d  = {1'b0, shreg_q[7:1]};
                        bitcnt_d = bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd7) begin
                            bitcnt_d = 5'd0;
                            if (eof_q) begin
                                state_d = FCS;
                            end else if (hvld_q) begin
                                shreg_d = hold_q[7:0];
                                eof_d   = hold_q[8];
                                hvld_d  = 1'b0;
                            end else begin
                                state_d = ABORT;
                                abort_d = 1'b1;
                                drop_d  = 1'b1;
                            end
                        end
                    end
                end
                FCS: begin
                    // A run of five ones at the end of the FCS still needs its stuffed zero before the flag.
                    if (stuff) begin
                        if (bitcnt_q[4]) begin
                            state_d  = CLOSE;
                            bitcnt_d = 5'd0;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 5'd1;
                        if (bitcnt_q == 5'd15 && ones_d != STUFF_RUN) begin
                            state_d  = CLOSE;
                            bitcnt_d = 5'd0;
                        end
                    end
                end
                CLOSE, ABORT: begin
                    bitcnt_d = bitcnt_q + 5'd1;
                    if (bitcnt_q == 5'd7) begin
                        state_d  = IDLE;
                        bitcnt_d = 5'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            hvld_q    <= 1'b0;
            drop_q    <= 1'b0;
            shreg_q   <= '0;
            eof_q     <= 1'b0;
            bitcnt_q  <= '0;
            flagcnt_q <= '0;
            ones_q    <= '0;
            sdo_q     <= 1'b1;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            hvld_q    <= hvld_d;
            drop_q    <= drop_d;
            shreg_q   <= shreg_d;
            eof_q     <= eof_d;
            bitcnt_q  <= bitcnt_d;
            flagcnt_q <= flagcnt_d;
            ones_q    <= ones_d;
            sdo_q     <= sdo_d;
            abort_q   <= abort_d;
        end
    end

endmodule
